// File: rtl/cycle_delta_pkg.sv
// rtl/cycle_delta_pkg.sv - register map, CTRL bit positions and FSM encoding for cycle_delta_capture
package cycle_delta_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int CTRL_ARM    = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_CONT   = 2;
  localparam int CTRL_ABORT  = 3;
  localparam int CTRL_IRQ_EN = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_MEASURING = 2'd2
  } state_t;

endpackage

// File: rtl/delta_fifo.sv
// rtl/delta_fifo.sv - synchronous delta FIFO with push/pop/clear and sticky overflow
module delta_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_push) overflow <= 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cycle_delta_capture.sv
// rtl/cycle_delta_capture.sv - start/stop cycle delta capture with Avalon-MM registers (optional irq: CYCLE_DELTA_IRQ_EN)
module cycle_delta_capture
  import cycle_delta_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic [31:0] clk_count,
  input  logic        start_evt,
  input  logic        stop_evt,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic            cont;
  logic [31:0]     start_q;
  logic            latch_start;
  logic            push;
  logic            ctrl_wr;
  logic            abort;
  logic            arm;
  logic            clear;
  logic            pop;
  logic [31:0]     head;
  logic            full;
  logic            empty;
  logic            overflow;
  logic [CW-1:0]   count;

  assign ctrl_wr = write && (address == ADDR_CTRL);
  assign abort   = ctrl_wr && writedata[CTRL_ABORT];
  assign arm     = ctrl_wr && writedata[CTRL_ARM];
  assign clear   = ctrl_wr && writedata[CTRL_CLEAR];
  assign pop     = read && (address == ADDR_DATA);

  always_comb begin
    state_nxt   = state;
    latch_start = 1'b0;
    push        = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (arm) state_nxt = ST_ARMED;
        ST_ARMED: if (start_evt) begin
          latch_start = 1'b1;
          state_nxt   = ST_MEASURING;
        end
        ST_MEASURING: if (stop_evt) begin
          push      = 1'b1;
          state_nxt = cont ? ST_ARMED : ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cont    <= 1'b0;
      start_q <= '0;
    end else begin
      state <= state_nxt;
      if (ctrl_wr)     cont    <= writedata[CTRL_CONT];
      if (latch_start) start_q <= clk_count;
    end
  end

  // Unsigned 32-bit subtraction gives the right delta across a counter wrap.
  delta_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .wdata    (clk_count - start_q),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

`ifdef CYCLE_DELTA_IRQ_EN
  logic irq_en;
  logic irq_q;
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:5];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= writedata[CTRL_IRQ_EN];
      irq_q <= irq_en & (!empty | overflow);
    end
  end
  assign irq = irq_q;
`else
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:4];
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_CONT] = cont;
`ifdef CYCLE_DELTA_IRQ_EN
        readdata[CTRL_IRQ_EN] = irq_en;
`endif
      end
      ADDR_DATA:   readdata = head;
      ADDR_STATUS: readdata = {16'b0, 8'(count), 3'b0, overflow, full, empty, state};
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cycle_delta_capture.sv
// tb/tb_cycle_delta_capture.sv - self-checking bench for cycle_delta_capture (vector table, directed corners, random vs queue model)
`timescale 1ns/1ps
module tb_cycle_delta_capture;
  import cycle_delta_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic [31:0] clk_count = 32'd0;
  logic        start_evt = 1'b0;
  logic        stop_evt = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cycle_delta_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .clk_count (clk_count),
    .start_evt (start_evt),
    .stop_evt  (stop_evt),
    .irq       (irq)
  );

  // Reference model: a queue of deltas plus the few architectural registers.
  logic [31:0] mq[$];
  bit          m_ovf;
  bit          m_cont;
  bit          m_irqen;
  bit          m_irq;
  logic [1:0]  m_st;
  logic [31:0] m_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [7:0] c;
    c = 8'(mq.size());
    return {16'b0, c, 3'b0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0), m_st};
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {27'b0, m_irqen, 1'b0, m_cont, 2'b00};
      2'd1:    return (mq.size() > 0) ? mq[0] : 32'd0;
      2'd2:    return m_status();
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_cont = 0; m_irqen = 0; m_irq = 0;
    m_st = ST_IDLE; m_start = 32'd0;
  endtask

  task automatic model_edge(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                            input logic rd, input logic [31:0] cnt, input logic st, input logic sp);
    bit ctrl, clr, abrt, arm, do_pop, do_push;
    logic [31:0] d;
    ctrl    = wr && (a == 2'd0);
    clr     = ctrl && wd[1];
    abrt    = ctrl && wd[3];
    arm     = ctrl && wd[0];
    do_pop  = rd && (a == 2'd1) && (mq.size() > 0);
    do_push = 0;
    d       = cnt - m_start;
    m_irq   = m_irqen && ((mq.size() != 0) || m_ovf);
    if (abrt) m_st = ST_IDLE;
    else if (m_st == ST_IDLE) begin
      if (arm) m_st = ST_ARMED;
    end else if (m_st == ST_ARMED) begin
      if (st) begin m_start = cnt; m_st = ST_MEASURING; end
    end else if (sp) begin
      do_push = 1;
      m_st = m_cont ? ST_ARMED : ST_IDLE;
    end
    if (ctrl) begin
      m_cont = wd[2];
`ifdef CYCLE_DELTA_IRQ_EN
      m_irqen = wd[4];
`endif
    end
    if (clr) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1;
      end
    end
  endtask

  // One clock: drive, check pre-edge readdata, step model, check status and irq after the edge.
  task automatic cyc(input logic [1:0] a, input logic wr, input logic [31:0] wd, input logic rd,
                     input logic [31:0] cnt, input logic st, input logic sp,
                     output logic [31:0] pre, output logic [31:0] post);
    address = a; write = wr; writedata = wd; read = rd;
    clk_count = cnt; start_evt = st; stop_evt = sp;
    #1;
    pre = readdata;
    check("readdata_pre", readdata, m_read(a));
    model_edge(a, wr, wd, rd, cnt, st, sp);
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; start_evt = 1'b0; stop_evt = 1'b0;
    address = 2'd2;
    #1;
    post = readdata;
    check("status_post", readdata, m_status());
    check("irq_post", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    address = 2'd2;
    #1;
    check("rst_status", readdata, 32'h0000_0004);
    address = 2'd1;
    #1;
    check("rst_data", readdata, 32'd0);
    address = 2'd0;
    #1;
    check("rst_ctrl", readdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic        rd;
    logic [31:0] cnt;
    logic        st;
    logic        sp;
    logic [31:0] exp_pre;
    logic [31:0] exp_status;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] pre, post, rc, wd;
    logic [1:0]  a;
    logic        w, r, st, sp;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // ARM CONT=0, start at 100, stop at 350, pop 250; then start+stop collision and ABORT over ARM.
    tbl[0] = '{2'd0, 1'b1, 32'h1, 1'b0, 32'd0,   1'b0, 1'b0, 32'h0,   32'h5};
    tbl[1] = '{2'd2, 1'b0, 32'h0, 1'b0, 32'd100, 1'b1, 1'b0, 32'h5,   32'h6};
    tbl[2] = '{2'd2, 1'b0, 32'h0, 1'b0, 32'd200, 1'b0, 1'b0, 32'h6,   32'h6};
    tbl[3] = '{2'd2, 1'b0, 32'h0, 1'b0, 32'd350, 1'b0, 1'b1, 32'h6,   32'h100};
    tbl[4] = '{2'd1, 1'b0, 32'h0, 1'b1, 32'd360, 1'b0, 1'b0, 32'd250, 32'h4};
    tbl[5] = '{2'd0, 1'b1, 32'h1, 1'b0, 32'd370, 1'b0, 1'b0, 32'h0,   32'h5};
    tbl[6] = '{2'd2, 1'b0, 32'h0, 1'b0, 32'd400, 1'b1, 1'b1, 32'h5,   32'h6};
    tbl[7] = '{2'd0, 1'b1, 32'h9, 1'b0, 32'd410, 1'b0, 1'b0, 32'h0,   32'h4};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].cnt, tbl[i].st, tbl[i].sp, pre, post);
      check($sformatf("vec%0d_pre", i), pre, tbl[i].exp_pre);
      check($sformatf("vec%0d_status", i), post, tbl[i].exp_status);
    end

    // Counter wrap.
    cyc(2'd0, 1'b1, 32'h1, 1'b0, 32'd0, 1'b0, 1'b0, pre, post);
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFF0, 1'b1, 1'b0, pre, post);
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'h0000_0010, 1'b0, 1'b1, pre, post);
    cyc(2'd1, 1'b0, 32'h0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, pre, post);
    check("wrap_delta", pre, 32'h20);

    // Overflow: CONT=1, nine measurements into eight slots.
    cyc(2'd0, 1'b1, 32'h6, 1'b0, 32'd0, 1'b0, 1'b0, pre, post);
    cyc(2'd0, 1'b1, 32'h5, 1'b0, 32'd0, 1'b0, 1'b0, pre, post);
    for (int i = 0; i < 9; i++) begin
      cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'(1000 * i), 1'b1, 1'b0, pre, post);
      cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'(1000 * i + 10 + i), 1'b0, 1'b1, pre, post);
    end
    check("ovf_status", post, 32'h0000_0819);
    for (int i = 0; i < 8; i++) begin
      cyc(2'd1, 1'b0, 32'h0, 1'b1, 32'd9000, 1'b0, 1'b0, pre, post);
      check($sformatf("ovf_data%0d", i), pre, 32'(10 + i));
    end
    check("ovf_drained", post, 32'h0000_0015);
    cyc(2'd0, 1'b1, 32'h6, 1'b0, 32'd9000, 1'b0, 1'b0, pre, post);
    check("clear_status", post, 32'h0000_0005);

    // Stop and pop in the same cycle with three entries queued.
    for (int i = 0; i < 3; i++) begin
      cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'(100 * i), 1'b1, 1'b0, pre, post);
      cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'(100 * i + 5 + i), 1'b0, 1'b1, pre, post);
    end
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'd500, 1'b1, 1'b0, pre, post);
    cyc(2'd1, 1'b0, 32'h0, 1'b1, 32'd509, 1'b0, 1'b1, pre, post);
    check("simul_head", pre, 32'd5);
    check("simul_status", post, 32'h0000_0301);
    cyc(2'd1, 1'b0, 32'h0, 1'b1, 32'd509, 1'b0, 1'b0, pre, post);
    check("simul_d1", pre, 32'd6);
    cyc(2'd1, 1'b0, 32'h0, 1'b1, 32'd509, 1'b0, 1'b0, pre, post);
    check("simul_d2", pre, 32'd7);
    cyc(2'd1, 1'b0, 32'h0, 1'b1, 32'd509, 1'b0, 1'b0, pre, post);
    check("simul_d3", pre, 32'd9);

    // Reset during MEASURING discards the measurement.
    cyc(2'd0, 1'b1, 32'h8, 1'b0, 32'd600, 1'b0, 1'b0, pre, post);
    cyc(2'd0, 1'b1, 32'h1, 1'b0, 32'd600, 1'b0, 1'b0, pre, post);
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'd700, 1'b1, 1'b0, pre, post);
    check("meas_before_rst", post, 32'h0000_0006);
    do_reset();
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'd800, 1'b0, 1'b1, pre, post);
    check("rst_mid_meas", post, 32'h0000_0004);

`ifdef CYCLE_DELTA_IRQ_EN
    cyc(2'd0, 1'b1, 32'h11, 1'b0, 32'd0, 1'b0, 1'b0, pre, post);
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'd10, 1'b1, 1'b0, pre, post);
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'd30, 1'b0, 1'b1, pre, post);
    check("irq_at_push", {31'b0, irq}, 32'd0);
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'd40, 1'b0, 1'b0, pre, post);
    check("irq_after_push", {31'b0, irq}, 32'd1);
    cyc(2'd1, 1'b0, 32'h0, 1'b1, 32'd40, 1'b0, 1'b0, pre, post);
    check("irq_data", pre, 32'd20);
    cyc(2'd2, 1'b0, 32'h0, 1'b0, 32'd40, 1'b0, 1'b0, pre, post);
    check("irq_after_pop", {31'b0, irq}, 32'd0);
`endif

    // Random traffic against the queue model.
    rc = 32'd0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) rc = 32'hFFFF_FF00 + 32'($urandom_range(0, 200));
      else rc = rc + 32'($urandom_range(1, 40));
      w = ($urandom_range(0, 7) == 0);
      a = (w && $urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
      wd = $urandom & 32'h0000_0015;
      if ($urandom_range(0, 7) == 0) wd[1] = 1'b1;
      if ($urandom_range(0, 5) == 0) wd[3] = 1'b1;
      r  = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 3) == 0);
      cyc(a, w, wd, r, rc, st, sp, pre, post);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
